// File: rtl/ctrl_pkg.sv
// Shared encodings and control bundles for the pipelined ARM-subset control unit.
// Optional feature macro: CTRL_BL_EN (branch-with-link decode).
package ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] RSRC_NONE  = 2'b00;
  localparam logic [1:0] RSRC_PC    = 2'b01;
  localparam logic [1:0] RSRC_RD    = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Decode-stage bundle produced by the decoder.
  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       pcs;
    logic       link;
    logic [1:0] flag_w;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
  } ctrl_t;

  // Contents of the D->E register; all-zero is a bubble.
  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic [1:0] alu_control;
    logic       alu_src;
    logic       mem_to_reg;
  } e_stage_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational main + ALU decoder: instruction -> Decode-stage control bundle.
// With CTRL_BL_EN defined, Op10 with Funct[4]=1 decodes as BL (register write + link).
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       arith;
  logic       legal;

  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rd    = instr[15:12];

  // Condition field is consumed by the pipeline, the rest is operand encoding.
  logic unused_bits;
  assign unused_bits = ^{instr[INSTR_W-1:28], instr[19:16], instr[11:0]};

  always_comb begin
    ctrl  = '0;
    arith = 1'b0;
    legal = 1'b0;
    case (op)
      OP_DP: begin
        ctrl.alu_src = funct[5];
        ctrl.imm_src = IMM_8;
        ctrl.reg_src = RSRC_NONE;
        case (funct[4:1])
          CMD_ADD: begin ctrl.alu_control = ALU_ADD; legal = 1'b1; arith = 1'b1; end
          CMD_SUB: begin ctrl.alu_control = ALU_SUB; legal = 1'b1; arith = 1'b1; end
          CMD_AND: begin ctrl.alu_control = ALU_AND; legal = 1'b1; end
          CMD_ORR: begin ctrl.alu_control = ALU_ORR; legal = 1'b1; end
          default: ctrl.alu_control = ALU_ADD;
        endcase
        ctrl.reg_w  = legal;
        ctrl.flag_w = {funct[0] & legal, funct[0] & arith};
      end
      OP_MEM: begin
        ctrl.alu_src     = 1'b1;
        ctrl.imm_src     = IMM_12;
        ctrl.alu_control = ALU_ADD;
        if (funct[0]) begin
          ctrl.reg_w      = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_src    = RSRC_NONE;
        end else begin
          ctrl.mem_w   = 1'b1;
          ctrl.reg_src = RSRC_RD;
        end
      end
      OP_BR: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.imm_src     = IMM_24;
        ctrl.reg_src     = RSRC_PC;
        ctrl.alu_control = ALU_ADD;
`ifdef CTRL_BL_EN
        ctrl.reg_w = funct[4];
        ctrl.link  = funct[4];
`endif
      end
      default: ctrl = '0;
    endcase
    // BL writes R14 implicitly, so Rd must not turn it into a PC write.
    ctrl.pcs = ctrl.branch | (ctrl.reg_w & (rd == 4'hF) & (op != OP_BR));
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipelined control unit: decodes in D and carries controls through E/M/W registers.
// Optional feature macro: CTRL_BL_EN adds the Link D->W pipe feeding LinkW.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic               FlushE,
  input  logic               PCSrcE,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  output logic [1:0]         ImmSrcD,
  output logic [1:0]         RegSrcD,
  output logic [3:0]         CondE,
  output logic [1:0]         FlagWE,
  output logic               PCSE,
  output logic               RegWE,
  output logic               MemWE,
  output logic               BranchE,
  output logic [1:0]         ALUControlE,
  output logic               ALUSrcE,
  output logic               MemtoRegE,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic               MemtoRegM,
  output logic               PCSrcM,
  output logic               RegWriteW,
  output logic               MemtoRegW,
  output logic               PCSrcW,
  output logic               LinkW
);

  ctrl_t    ctrl_d;
  e_stage_t e_d;
  e_stage_t e_q;

  ctrl_decoder #(.INSTR_W(INSTR_W)) u_decoder (
    .instr (InstrD),
    .ctrl  (ctrl_d)
  );

  assign ImmSrcD = ctrl_d.imm_src;
  assign RegSrcD = ctrl_d.reg_src;

  always_comb begin
    e_d             = '0;
    e_d.cond        = InstrD[31:28];
    e_d.flag_w      = ctrl_d.flag_w;
    e_d.pcs         = ctrl_d.pcs;
    e_d.reg_w       = ctrl_d.reg_w;
    e_d.mem_w       = ctrl_d.mem_w;
    e_d.branch      = ctrl_d.branch;
    e_d.alu_control = ctrl_d.alu_control;
    e_d.alu_src     = ctrl_d.alu_src;
    e_d.mem_to_reg  = ctrl_d.mem_to_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      e_q <= '0;
    else if (FlushE) e_q <= '0;
    else             e_q <= e_d;
  end

  assign CondE       = e_q.cond;
  assign FlagWE      = e_q.flag_w;
  assign PCSE        = e_q.pcs;
  assign RegWE       = e_q.reg_w;
  assign MemWE       = e_q.mem_w;
  assign BranchE     = e_q.branch;
  assign ALUControlE = e_q.alu_control;
  assign ALUSrcE     = e_q.alu_src;
  assign MemtoRegE   = e_q.mem_to_reg;

  // Memory takes the condition-gated writes returned by the conditional logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      PCSrcM    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      RegWriteM <= RegWriteE;
      MemWriteM <= MemWriteE;
      MemtoRegM <= e_q.mem_to_reg;
      PCSrcM    <= PCSrcE;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      PCSrcW    <= PCSrcM;
    end
  end

`ifdef CTRL_BL_EN
  logic link_e;
  logic link_m;
  logic link_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link_e <= 1'b0;
      link_m <= 1'b0;
      link_w <= 1'b0;
    end else begin
      link_e <= FlushE ? 1'b0 : ctrl_d.link;
      link_m <= link_e;
      link_w <= link_m;
    end
  end

  assign LinkW = link_w;
`else
  logic unused_link;
  assign unused_link = ctrl_d.link;
  assign LinkW       = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed steps plus a short random tail, scoreboard queues per stage.
module tb_ctrl_pipeline;

`ifdef CTRL_BL_EN
  localparam logic BL = 1'b1;
`else
  localparam logic BL = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] InstrD;
  logic        FlushE, PCSrcE, RegWriteE, MemWriteE;
  logic [1:0]  ImmSrcD, RegSrcD, FlagWE, ALUControlE;
  logic [3:0]  CondE;
  logic        PCSE, RegWE, MemWE, BranchE, ALUSrcE, MemtoRegE;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic        RegWriteW, MemtoRegW, PCSrcW, LinkW;

  ctrl_pipeline #(.INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ImmSrcD(ImmSrcD), .RegSrcD(RegSrcD), .CondE(CondE), .FlagWE(FlagWE),
    .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .LinkW(LinkW)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Scoreboard: E vector {cond,flag_w,pcs,rw,mw,br,alu,src,m2r}; M/W vector {rw,mw,m2r,pcsrc,link}
  logic [13:0] exp_e_q[$];
  logic [4:0]  exp_m_q[$];
  logic [4:0]  exp_w_q[$];
  logic [13:0] cur_e;
  logic        cur_pass;
  logic        cur_link;

  logic [31:0] t_instr[11];
  logic [13:0] t_e[11];
  logic        t_link[11];
  logic [1:0]  t_imm[11];
  logic [1:0]  t_rs[11];

  function automatic logic [13:0] mk(input logic [3:0] cond, input logic [1:0] flag,
                                     input logic pcs, input logic rw, input logic mw,
                                     input logic br, input logic [1:0] alu,
                                     input logic src, input logic m2r);
    return {cond, flag, pcs, rw, mw, br, alu, src, m2r};
  endfunction

  function automatic logic [13:0] dut_e();
    return {CondE, FlagWE, PCSE, RegWE, MemWE, BranchE, ALUControlE, ALUSrcE, MemtoRegE};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_clear();
    exp_e_q.delete();
    exp_m_q.delete();
    exp_w_q.delete();
    exp_w_q.push_back(5'b0);
    cur_e    = '0;
    cur_pass = 1'b0;
    cur_link = 1'b0;
  endtask

  // Driver: starts at a falling edge, ends at the next falling edge.
  task automatic step(input string tag, input logic [31:0] instr, input logic flush,
                      input logic pass, input logic [13:0] exp_e, input logic exp_link,
                      input logic [1:0] exp_imm, input logic [1:0] exp_rs);
    logic [4:0]  m_exp;
    logic [13:0] e_pop;
    logic [4:0]  m_pop;
    logic [4:0]  w_pop;
    InstrD    = instr;
    FlushE    = flush;
    RegWriteE = cur_pass & cur_e[6];
    MemWriteE = cur_pass & cur_e[5];
    PCSrcE    = cur_pass & cur_e[7];
    m_exp = {RegWriteE, MemWriteE, cur_e[0], PCSrcE, cur_link};
    exp_e_q.push_back(flush ? 14'b0 : exp_e);
    exp_m_q.push_back(m_exp);
    exp_w_q.push_back(m_exp);
    #1;
    check({tag, ".ImmSrcD"}, 32'(ImmSrcD), 32'(exp_imm));
    check({tag, ".RegSrcD"}, 32'(RegSrcD), 32'(exp_rs));
    @(posedge clk);
    #1;
    e_pop = exp_e_q.pop_front();
    m_pop = exp_m_q.pop_front();
    w_pop = exp_w_q.pop_front();
    check({tag, ".E"}, 32'(dut_e()), 32'(e_pop));
    check({tag, ".M"}, 32'({RegWriteM, MemWriteM, MemtoRegM, PCSrcM}), 32'(m_pop[4:1]));
    check({tag, ".W"}, 32'({RegWriteW, MemtoRegW, PCSrcW, LinkW}),
          32'({w_pop[4], w_pop[2], w_pop[1], w_pop[0]}));
    cur_e    = flush ? 14'b0 : exp_e;
    cur_pass = flush ? 1'b0 : pass;
    cur_link = flush ? 1'b0 : exp_link;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int k, input logic flush, input logic pass);
    step(tag, t_instr[k], flush, pass, t_e[k], t_link[k], t_imm[k], t_rs[k]);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step("drain", 32'h0, 1'b1, 1'b0, 14'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".E"}, 32'(dut_e()), 32'h0);
    check({tag, ".M"}, 32'({RegWriteM, MemWriteM, MemtoRegM, PCSrcM}), 32'h0);
    check({tag, ".W"}, 32'({RegWriteW, MemtoRegW, PCSrcW, LinkW}), 32'h0);
  endtask

  initial begin
    t_instr[0]  = 32'hE2921001; t_e[0]  = mk(4'hE, 2'b11, 0, 1, 0, 0, 2'b00, 1, 0); t_imm[0]  = 2'b00; t_rs[0]  = 2'b00; t_link[0]  = 0;
    t_instr[1]  = 32'hE5910000; t_e[1]  = mk(4'hE, 2'b00, 0, 1, 0, 0, 2'b00, 1, 1); t_imm[1]  = 2'b01; t_rs[1]  = 2'b00; t_link[1]  = 0;
    t_instr[2]  = 32'h1A000002; t_e[2]  = mk(4'h1, 2'b00, 1, 0, 0, 1, 2'b00, 1, 0); t_imm[2]  = 2'b10; t_rs[2]  = 2'b01; t_link[2]  = 0;
    t_instr[3]  = 32'hE5810000; t_e[3]  = mk(4'hE, 2'b00, 0, 0, 1, 0, 2'b00, 1, 0); t_imm[3]  = 2'b01; t_rs[3]  = 2'b10; t_link[3]  = 0;
    t_instr[4]  = 32'hE0443005; t_e[4]  = mk(4'hE, 2'b00, 0, 1, 0, 0, 2'b01, 0, 0); t_imm[4]  = 2'b00; t_rs[4]  = 2'b00; t_link[4]  = 0;
    t_instr[5]  = 32'hE1943005; t_e[5]  = mk(4'hE, 2'b10, 0, 1, 0, 0, 2'b11, 0, 0); t_imm[5]  = 2'b00; t_rs[5]  = 2'b00; t_link[5]  = 0;
    t_instr[6]  = 32'hE0012003; t_e[6]  = mk(4'hE, 2'b00, 0, 1, 0, 0, 2'b10, 0, 0); t_imm[6]  = 2'b00; t_rs[6]  = 2'b00; t_link[6]  = 0;
    t_instr[7]  = 32'hE0212003; t_e[7]  = mk(4'hE, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0); t_imm[7]  = 2'b00; t_rs[7]  = 2'b00; t_link[7]  = 0;
    t_instr[8]  = 32'hE281F004; t_e[8]  = mk(4'hE, 2'b00, 1, 1, 0, 0, 2'b00, 1, 0); t_imm[8]  = 2'b00; t_rs[8]  = 2'b00; t_link[8]  = 0;
    t_instr[9]  = 32'hEC000000; t_e[9]  = mk(4'hE, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0); t_imm[9]  = 2'b00; t_rs[9]  = 2'b00; t_link[9]  = 0;
    t_instr[10] = 32'hEB000004; t_e[10] = mk(4'hE, 2'b00, 1, BL, 0, 1, 2'b00, 1, 0); t_imm[10] = 2'b10; t_rs[10] = 2'b01; t_link[10] = BL;

    reset = 1'b0; InstrD = 32'h0; FlushE = 1'b0;
    PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
    sb_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    run("adds",  0, 1'b0, 1'b1);
    run("ldr",   1, 1'b0, 1'b1);
    run("bne",   2, 1'b0, 1'b0);
    run("str_flush", 3, 1'b1, 1'b1);
    run("sub",   4, 1'b0, 1'b1);
    run("orrs",  5, 1'b0, 1'b1);
    run("and",   6, 1'b0, 1'b1);
    run("eor",   7, 1'b0, 1'b1);
    run("add_pc", 8, 1'b0, 1'b1);
    run("op11",  9, 1'b0, 1'b1);
    run("bl",   10, 1'b0, 1'b1);
    run("str",   3, 1'b0, 1'b1);
    drain();

    // Asynchronous reset mid-stream, sampled well before the next rising edge.
    run("pre_rst_adds", 0, 1'b0, 1'b1);
    run("pre_rst_ldr",  1, 1'b0, 1'b1);
    run("pre_rst_bl",  10, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    sb_clear();
    reset = 1'b1;
    run("restart_adds", 0, 1'b0, 1'b1);
    run("restart_ldr",  1, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 16; i++) begin
      int k;
      k = $urandom_range(0, 10);
      run("rand", k, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
